// File: rtl/wr_frame_packer.sv
// Packs source frames into header-prefixed segments of up to MAXLEN bytes for an async FIFO write side.
// The header is written the cycle after the ending beat, then the bytes; wfull stalls the writes and s_ready is low while draining.
module wr_frame_packer #(
  parameter int DW     = 8,
  parameter int MAXLEN = 16
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          wfull,
  output logic          winc,
  output logic [DW-1:0] wdata,
  output logic [15:0]   seg_count,
  output logic          busy
);

  localparam int IW = $clog2(MAXLEN);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HEADER  = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_buf [MAXLEN];
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_idx;
  logic [6:0]    r_len;
  logic          r_last;
  logic [15:0]   r_seg_count;

  logic          w_accept;
  logic          w_end;
  logic          w_drain_done;
  logic [CW-1:0] w_cnt_inc;
  logic [DW-1:0] w_hdr;

  // Outputs decode only from registered state and wfull; source inputs feed next-state logic only.
  always_comb begin
    w_state_nxt  = r_state;
    s_ready      = 1'b0;
    busy         = 1'b1;
    winc         = 1'b0;
    wdata        = '0;
    w_accept     = 1'b0;
    w_end        = 1'b0;
    w_drain_done = 1'b0;
    w_cnt_inc    = r_count + 1'b1;
    w_hdr        = '0;
    w_hdr[7]     = r_last;
    w_hdr[6:0]   = r_len;
    case (r_state)
      COLLECT: begin
        s_ready  = 1'b1;
        busy     = 1'b0;
        w_accept = s_valid;
        w_end    = s_valid && (s_last || (w_cnt_inc == CW'(MAXLEN)));
        if (w_end) w_state_nxt = HEADER;
      end
      HEADER: begin
        winc  = !wfull;
        wdata = w_hdr;
        if (!wfull) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        winc         = !wfull;
        wdata        = r_buf[r_idx];
        w_drain_done = !wfull && (7'(r_idx) == (r_len - 7'd1));
        if (w_drain_done) w_state_nxt = COLLECT;
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_state <= COLLECT;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_last      <= 1'b0;
      r_seg_count <= '0;
    end else begin
      if (w_accept) r_count <= w_cnt_inc;
      if (w_end) begin
        r_len  <= 7'(w_cnt_inc);
        r_last <= s_last;
      end
      if (r_state == HEADER && !wfull) r_idx <= '0;
      if (r_state == DRAIN && !wfull)  r_idx <= r_idx + 1'b1;
      if (w_drain_done) begin
        r_count     <= '0;
        r_seg_count <= r_seg_count + 16'd1;
      end
    end
  end

  // Staging buffer carries no reset; it is always rewritten before being drained.
  always_ff @(posedge wclk) begin
    if (w_accept) r_buf[r_count[IW-1:0]] <= s_data;
  end

  assign seg_count = r_seg_count;

endmodule

// File: tb/tb_wr_frame_packer.sv
// Bench for wr_frame_packer: queue-based segmentation model checked every cycle, plus literal frame checks.
module tb_wr_frame_packer;
  localparam int DW     = 8;
  localparam int MAXLEN = 16;

  logic          wclk    = 1'b0;
  logic          wrst_n  = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_last  = 1'b0;
  logic          wfull   = 1'b0;
  logic          s_ready;
  logic          winc;
  logic [DW-1:0] wdata;
  logic [15:0]   seg_count;
  logic          busy;

  wr_frame_packer #(.DW(DW), .MAXLEN(MAXLEN)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .seg_count(seg_count), .busy(busy)
  );

  always #5 wclk = ~wclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_end_cyc = 0;
  bit          rand_full = 1'b0;
  logic [8:0]  q_exp[$];     // {segment-final flag, byte}
  logic [7:0]  m_seg[$];
  logic [15:0] m_segs = '0;
  logic [7:0]  q_log[$];
  int          q_lcyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: accepted beats are grouped into segments, each expanded to header + bytes.
  always @(negedge wclk) begin
    logic [8:0] e;
    cyc++;
    if (wrst_n) begin
      chk("winc_while_full", 32'(winc && wfull), 0);
      chk("ready_vs_busy", 32'(s_ready), 32'(!busy));
      chk("winc_decode", 32'(winc), 32'(busy && !wfull));
      if (!busy) chk("idle_wdata", 32'(wdata), 0);
      chk("seg_count", 32'(seg_count), 32'(m_segs));
      if (winc) begin
        q_log.push_back(wdata);
        q_lcyc.push_back(cyc);
        if (q_exp.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got 0x%0h, expected no write", wdata);
        end else begin
          e = q_exp.pop_front();
          chk("write_byte", 32'(wdata), 32'(e[7:0]));
          if (e[8]) m_segs++;
        end
      end
      if (s_valid && s_ready) begin
        m_seg.push_back(s_data);
        if (s_last || m_seg.size() == MAXLEN) begin
          q_exp.push_back({1'b0, s_last, 7'(m_seg.size())});
          for (int i = 0; i < m_seg.size(); i++)
            q_exp.push_back({(i == m_seg.size() - 1), m_seg[i]});
          m_seg.delete();
          acc_end_cyc = cyc;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge wclk);
      #1;
      if (rand_full) wfull = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    bit rdy;
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      @(negedge wclk);
      rdy = s_ready;
      @(posedge wclk);
      #1;
      t++;
    end while (!rdy && t < 300);
    if (!rdy) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got s_ready=0, expected 1 within 300 cycles");
    end
  endtask

  task automatic send_frame(input logic [7:0] d[$], input int gaps);
    for (int i = 0; i < d.size(); i++) begin
      int g = $urandom_range(0, gaps);
      if (g > 0) begin
        s_valid = 1'b0;
        repeat (g) @(posedge wclk);
        #1;
      end
      send_beat(d[i], (i == d.size() - 1));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    do begin
      @(negedge wclk);
      t++;
    end while ((busy || q_exp.size() != 0) && t < 3000);
    chk({name, "_idle"}, 32'(t < 3000), 1);
    @(posedge wclk);
    #1;
  endtask

  task automatic clear_log();
    q_log.delete();
    q_lcyc.delete();
  endtask

  task automatic chk_log(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, 32'(q_log.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < q_log.size(); i++)
      chk($sformatf("%s_b%0d", name, i), 32'(q_log[i]), 32'(e[i]));
  endtask

  task automatic chk_consec(input string name, input int first, input int n);
    for (int i = 1; i < n; i++)
      if (first + i < q_lcyc.size())
        chk($sformatf("%s_cyc%0d", name, first + i), 32'(q_lcyc[first + i]), 32'(q_lcyc[first] + i));
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] e[$];
    int exp_segs;

    #12;
    chk("rst_winc", 32'(winc), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_seg", 32'(seg_count), 0);
    #10 wrst_n = 1'b1;
    @(posedge wclk);
    #1;

    // Three-byte frame
    clear_log();
    d = '{8'hA1, 8'hA2, 8'hA3};
    send_frame(d, 0);
    wait_idle("f3");
    e = '{8'h83, 8'hA1, 8'hA2, 8'hA3};
    chk_log("f3", e);
    if (q_lcyc.size() > 0) chk("f3_hdr_cycle", 32'(q_lcyc[0]), 32'(acc_end_cyc + 1));
    chk_consec("f3", 0, 4);
    chk("f3_segs", 32'(seg_count), 1);

    // Twenty-byte frame split into 16 + 4
    clear_log();
    d.delete();
    for (int i = 0; i < 20; i++) d.push_back(8'(8'h20 + i));
    send_frame(d, 1);
    wait_idle("f20");
    e = '{8'h10};
    for (int i = 0; i < 16; i++) e.push_back(d[i]);
    e.push_back(8'h84);
    for (int i = 16; i < 20; i++) e.push_back(d[i]);
    chk_log("f20", e);
    chk_consec("f20a", 0, 17);
    chk_consec("f20b", 17, 5);
    chk("f20_segs", 32'(seg_count), 3);

    // Sixteen bytes with last on the final byte
    clear_log();
    d.delete();
    for (int i = 0; i < 16; i++) d.push_back(8'(8'h40 + i));
    send_frame(d, 0);
    wait_idle("f16");
    e = '{8'h90};
    for (int i = 0; i < 16; i++) e.push_back(d[i]);
    chk_log("f16", e);
    chk_consec("f16", 0, 17);
    chk("f16_segs", 32'(seg_count), 4);

    // Five-cycle stall while draining
    clear_log();
    d.delete();
    for (int i = 0; i < 10; i++) d.push_back(8'(8'h60 + i));
    send_frame(d, 0);
    repeat (2) @(posedge wclk);
    #1 wfull = 1'b1;
    repeat (5) begin
      @(negedge wclk);
      chk("stall_winc", 32'(winc), 0);
      chk("stall_wdata", 32'(wdata), 32'h61);
    end
    @(posedge wclk);
    #1 wfull = 1'b0;
    wait_idle("stall");
    e = '{8'h8A};
    for (int i = 0; i < 10; i++) e.push_back(d[i]);
    chk_log("stall", e);
    if (q_lcyc.size() > 2) chk("stall_gap", 32'(q_lcyc[2] - q_lcyc[1]), 6);
    chk("stall_segs", 32'(seg_count), 5);

    // Reset in the middle of a drain
    d.delete();
    for (int i = 0; i < 10; i++) d.push_back(8'(8'h70 + i));
    send_frame(d, 0);
    repeat (3) @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1;
    chk("rst2_winc", 32'(winc), 0);
    chk("rst2_wdata", 32'(wdata), 0);
    chk("rst2_busy", 32'(busy), 0);
    chk("rst2_ready", 32'(s_ready), 1);
    chk("rst2_seg", 32'(seg_count), 0);
    q_exp.delete();
    m_seg.delete();
    m_segs = '0;
    @(posedge wclk);
    #3 wrst_n = 1'b1;
    repeat (5) begin
      @(negedge wclk);
      chk("post_rst_winc", 32'(winc), 0);
    end
    @(posedge wclk);
    #1;
    clear_log();
    d = '{8'h55};
    send_frame(d, 0);
    wait_idle("after_rst");
    e = '{8'h81, 8'h55};
    chk_log("after_rst", e);
    chk("after_rst_segs", 32'(seg_count), 1);

    // Two single-byte frames back to back
    clear_log();
    send_beat(8'h11, 1'b1);
    send_beat(8'h22, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_idle("b2b");
    e = '{8'h81, 8'h11, 8'h81, 8'h22};
    chk_log("b2b", e);
    if (q_lcyc.size() == 4) begin
      chk("b2b_c1", 32'(q_lcyc[1]), 32'(q_lcyc[0] + 1));
      chk("b2b_c2", 32'(q_lcyc[2]), 32'(q_lcyc[0] + 3));
      chk("b2b_c3", 32'(q_lcyc[3]), 32'(q_lcyc[0] + 4));
    end
    chk("b2b_segs", 32'(seg_count), 3);

    // Random frames with random FIFO backpressure and source gaps
    exp_segs = 3;
    rand_full = 1'b1;
    for (int f = 0; f < 12; f++) begin
      int len = $urandom_range(1, 40);
      d.delete();
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      send_frame(d, 2);
      exp_segs += (len + MAXLEN - 1) / MAXLEN;
    end
    rand_full = 1'b0;
    @(posedge wclk);
    #2 wfull = 1'b0;
    wait_idle("rand");
    chk("rand_drained", 32'(q_exp.size()), 0);
    chk("rand_segs", 32'(seg_count), 32'(exp_segs));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
